// File: rtl/ahb_to_ri5cy.sv
// AHB-Lite slave to RI5CY req/gnt/rvalid memory bridge.
// One transfer outstanding; wait states until rvalid, two-cycle ERROR for illegal transfers.
module ahb_to_ri5cy #(
  parameter int AHB_ADDR_WIDTH = 32,
  parameter int AHB_DATA_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      hsel_i,
  input  logic [AHB_ADDR_WIDTH-1:0] haddr_i,
  input  logic [AHB_DATA_WIDTH-1:0] hwdata_i,
  input  logic                      hwrite_i,
  input  logic [2:0]                hsize_i,
  input  logic [2:0]                hburst_i,
  input  logic [3:0]                hprot_i,
  input  logic [1:0]                htrans_i,
  input  logic                      hmastlock_i,
  input  logic                      hready_i,
  output logic [AHB_DATA_WIDTH-1:0] hrdata_o,
  output logic                      hreadyout_o,
  output logic                      hresp_o,
  output logic                      req_o,
  output logic                      we_o,
  output logic [3:0]                be_o,
  output logic [31:0]               addr_o,
  output logic [31:0]               wdata_o,
  input  logic                      gnt_i,
  input  logic                      rvalid_i,
  input  logic [31:0]               rdata_i
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE,
    S_ERR1,
    S_ERR2
  } state_e;

  state_e                      state_q, state_d;
  logic [31:0]                 addr_q, addr_d;
  logic                        we_q, we_d;
  logic [3:0]                  be_q, be_d;
  logic [AHB_DATA_WIDTH-1:0]   hrdata_q, hrdata_d;

  logic [31:0] haddr_ext;
  logic        accept;
  logic        legal;
  logic [3:0]  be_new;

  // Address is truncated or zero-extended to the 32-bit memory side.
  generate
    if (AHB_ADDR_WIDTH >= 32) begin : g_addr_trunc
      assign haddr_ext = haddr_i[31:0];
    end else begin : g_addr_ext
      assign haddr_ext = {{(32-AHB_ADDR_WIDTH){1'b0}}, haddr_i};
    end
  endgenerate

  logic unused_inputs;
  assign unused_inputs = ^{hburst_i, hprot_i, hmastlock_i, htrans_i[0]};

  assign accept = hsel_i & hready_i & htrans_i[1];

  always_comb begin
    legal  = 1'b0;
    be_new = 4'b0000;
    case (hsize_i)
      3'd0: begin
        legal  = 1'b1;
        be_new = 4'b0001 << haddr_ext[1:0];
      end
      3'd1: begin
        legal  = ~haddr_ext[0];
        be_new = haddr_ext[1] ? 4'b1100 : 4'b0011;
      end
      3'd2: begin
        legal  = (haddr_ext[1:0] == 2'b00);
        be_new = 4'b1111;
      end
      default: begin
        legal  = 1'b0;
        be_new = 4'b0000;
      end
    endcase
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    we_d     = we_q;
    be_d     = be_q;
    hrdata_d = hrdata_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR2: begin
        if (accept) begin
          if (legal) begin
            state_d = S_REQ;
            addr_d  = {haddr_ext[31:2], 2'b00};
            we_d    = hwrite_i;
            be_d    = be_new;
          end else begin
            state_d = S_ERR1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REQ: begin
        if (gnt_i) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (rvalid_i) begin
          state_d = S_DONE;
          // Write responses leave the last read data on the bus.
          if (!we_q) begin
            hrdata_d = rdata_i;
          end
        end
      end
      S_ERR1: state_d = S_ERR2;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      we_q     <= 1'b0;
      be_q     <= '0;
      hrdata_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      be_q     <= be_d;
      hrdata_q <= hrdata_d;
    end
  end

  assign req_o       = (state_q == S_REQ);
  assign hreadyout_o = !((state_q == S_REQ) || (state_q == S_WAIT) || (state_q == S_ERR1));
  assign hresp_o     = (state_q == S_ERR1) || (state_q == S_ERR2);
  assign hrdata_o    = hrdata_q;
  assign we_o        = we_q;
  assign be_o        = be_q;
  assign addr_o      = addr_q;
  assign wdata_o     = hwdata_i;

endmodule

// File: tb/tb_ahb_to_ri5cy.sv
// Directed self-checking bench for ahb_to_ri5cy; inputs change and outputs are sampled 1ns after posedge.
module tb_ahb_to_ri5cy;

  logic        clk = 1'b0;
  logic        rstn;
  logic        hsel_i;
  logic [31:0] haddr_i;
  logic [31:0] hwdata_i;
  logic        hwrite_i;
  logic [2:0]  hsize_i;
  logic [2:0]  hburst_i;
  logic [3:0]  hprot_i;
  logic [1:0]  htrans_i;
  logic        hmastlock_i;
  logic        hready_i;
  logic [31:0] hrdata_o;
  logic        hreadyout_o;
  logic        hresp_o;
  logic        req_o;
  logic        we_o;
  logic [3:0]  be_o;
  logic [31:0] addr_o;
  logic [31:0] wdata_o;
  logic        gnt_i;
  logic        rvalid_i;
  logic [31:0] rdata_i;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Single-slave bus: the shared ready is this slave's own ready.
  assign hready_i = hreadyout_o;

  ahb_to_ri5cy #(.AHB_ADDR_WIDTH(32), .AHB_DATA_WIDTH(32)) dut (
    .clk(clk), .rstn(rstn),
    .hsel_i(hsel_i), .haddr_i(haddr_i), .hwdata_i(hwdata_i), .hwrite_i(hwrite_i),
    .hsize_i(hsize_i), .hburst_i(hburst_i), .hprot_i(hprot_i), .htrans_i(htrans_i),
    .hmastlock_i(hmastlock_i), .hready_i(hready_i),
    .hrdata_o(hrdata_o), .hreadyout_o(hreadyout_o), .hresp_o(hresp_o),
    .req_o(req_o), .we_o(we_o), .be_o(be_o), .addr_o(addr_o), .wdata_o(wdata_o),
    .gnt_i(gnt_i), .rvalid_i(rvalid_i), .rdata_i(rdata_i)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic addr_phase(input logic [31:0] a, input logic w, input logic [2:0] sz);
    hsel_i   = 1'b1;
    haddr_i  = a;
    hwrite_i = w;
    hsize_i  = sz;
    htrans_i = 2'b10;
  endtask

  task automatic bus_idle();
    hsel_i   = 1'b0;
    htrans_i = 2'b00;
  endtask

  initial begin
    rstn = 1'b0;
    hsel_i = 1'b0; haddr_i = '0; hwdata_i = '0; hwrite_i = 1'b0; hsize_i = '0;
    hburst_i = '0; hprot_i = '0; htrans_i = '0; hmastlock_i = 1'b0;
    gnt_i = 1'b0; rvalid_i = 1'b0; rdata_i = '0;
    cyc(); cyc();
    check("rst_hreadyout", 32'(hreadyout_o), 32'd1);
    check("rst_hresp", 32'(hresp_o), 32'd0);
    check("rst_hrdata", hrdata_o, 32'h0);
    check("rst_req", 32'(req_o), 32'd0);
    check("rst_we", 32'(we_o), 32'd0);
    check("rst_be", 32'(be_o), 32'd0);
    check("rst_addr", addr_o, 32'h0);
    rstn = 1'b1;
    cyc();
    // Idle bus: zero-wait OKAY, no request.
    check("idle_req", 32'(req_o), 32'd0);
    check("idle_hready", 32'(hreadyout_o), 32'd1);
    $display("txn: reset/idle done");

    // Word read 0x100
    addr_phase(32'h100, 1'b0, 3'd2);
    cyc();
    bus_idle(); gnt_i = 1'b1;
    check("wr_req_t1", 32'(req_o), 32'd1);
    check("wr_addr", addr_o, 32'h100);
    check("wr_be", 32'(be_o), 32'hF);
    check("wr_we", 32'(we_o), 32'd0);
    check("wr_hready_t1", 32'(hreadyout_o), 32'd0);
    cyc();
    gnt_i = 1'b0; rvalid_i = 1'b1; rdata_i = 32'hDEADBEEF;
    check("wr_req_t2", 32'(req_o), 32'd0);
    check("wr_hready_t2", 32'(hreadyout_o), 32'd0);
    cyc();
    rvalid_i = 1'b0; rdata_i = '0;
    check("wr_hready_t3", 32'(hreadyout_o), 32'd1);
    check("wr_hresp_t3", 32'(hresp_o), 32'd0);
    check("wr_hrdata", hrdata_o, 32'hDEADBEEF);
    $display("txn: word read 0x100 -> 0x%08h", hrdata_o);
    cyc();

    // Byte write 0x203
    addr_phase(32'h203, 1'b1, 3'd0);
    cyc();
    bus_idle(); hwdata_i = 32'hAA000000; gnt_i = 1'b1;
    check("bw_req", 32'(req_o), 32'd1);
    check("bw_be", 32'(be_o), 32'h8);
    check("bw_addr", addr_o, 32'h200);
    check("bw_we", 32'(we_o), 32'd1);
    check("bw_wdata", wdata_o, 32'hAA000000);
    cyc();
    gnt_i = 1'b0; rvalid_i = 1'b1; rdata_i = 32'h55555555;
    check("bw_wdata_t2", wdata_o, 32'hAA000000);
    cyc();
    rvalid_i = 1'b0; hwdata_i = '0;
    check("bw_hready_t3", 32'(hreadyout_o), 32'd1);
    check("bw_hresp_t3", 32'(hresp_o), 32'd0);
    check("bw_hrdata_kept", hrdata_o, 32'hDEADBEEF);
    $display("txn: byte write 0x203 done");
    cyc();

    // Halfword read 0x102, gnt delayed 3 cycles
    addr_phase(32'h102, 1'b0, 3'd1);
    cyc();
    bus_idle();
    for (int i = 0; i < 4; i++) begin
      gnt_i = (i == 3);
      check($sformatf("hr_req_%0d", i), 32'(req_o), 32'd1);
      check($sformatf("hr_be_%0d", i), 32'(be_o), 32'hC);
      check($sformatf("hr_addr_%0d", i), addr_o, 32'h100);
      check($sformatf("hr_hready_%0d", i), 32'(hreadyout_o), 32'd0);
      cyc();
    end
    gnt_i = 1'b0; rvalid_i = 1'b1; rdata_i = 32'h12345678;
    check("hr_req_wait", 32'(req_o), 32'd0);
    cyc();
    rvalid_i = 1'b0;
    check("hr_hready_t6", 32'(hreadyout_o), 32'd1);
    check("hr_hrdata", hrdata_o, 32'h12345678);
    $display("txn: half read 0x102 -> 0x%08h", hrdata_o);
    cyc();

    // Illegal transfers: misaligned word write, then hsize=3
    for (int k = 0; k < 2; k++) begin
      if (k == 0) addr_phase(32'h101, 1'b1, 3'd2);
      else        addr_phase(32'h0, 1'b0, 3'd3);
      cyc();
      bus_idle();
      check($sformatf("err%0d_resp_t1", k), 32'(hresp_o), 32'd1);
      check($sformatf("err%0d_hready_t1", k), 32'(hreadyout_o), 32'd0);
      check($sformatf("err%0d_req_t1", k), 32'(req_o), 32'd0);
      cyc();
      check($sformatf("err%0d_resp_t2", k), 32'(hresp_o), 32'd1);
      check($sformatf("err%0d_hready_t2", k), 32'(hreadyout_o), 32'd1);
      check($sformatf("err%0d_req_t2", k), 32'(req_o), 32'd0);
      cyc();
      check($sformatf("err%0d_resp_t3", k), 32'(hresp_o), 32'd0);
      check($sformatf("err%0d_hready_t3", k), 32'(hreadyout_o), 32'd1);
      $display("txn: illegal transfer %0d -> ERROR", k);
    end

    // Two pipelined reads, second presented in the DONE cycle
    addr_phase(32'h300, 1'b0, 3'd2);
    cyc();
    bus_idle(); gnt_i = 1'b1;
    check("p1_addr", addr_o, 32'h300);
    cyc();
    gnt_i = 1'b0; rvalid_i = 1'b1; rdata_i = 32'h11111111;
    cyc();
    rvalid_i = 1'b0;
    check("p1_hready", 32'(hreadyout_o), 32'd1);
    check("p1_hrdata", hrdata_o, 32'h11111111);
    $display("txn: pipelined read 0x300 -> 0x%08h", hrdata_o);
    addr_phase(32'h304, 1'b0, 3'd2);
    cyc();
    bus_idle(); gnt_i = 1'b1;
    check("p2_req", 32'(req_o), 32'd1);
    check("p2_addr", addr_o, 32'h304);
    cyc();
    gnt_i = 1'b0; rvalid_i = 1'b1; rdata_i = 32'h22222222;
    cyc();
    rvalid_i = 1'b0;
    check("p2_hready", 32'(hreadyout_o), 32'd1);
    check("p2_hrdata", hrdata_o, 32'h22222222);
    $display("txn: pipelined read 0x304 -> 0x%08h", hrdata_o);
    cyc();

    // Reset while in WAIT
    addr_phase(32'h400, 1'b0, 3'd2);
    cyc();
    bus_idle(); gnt_i = 1'b1;
    cyc();
    gnt_i = 1'b0;
    check("rw_wait_hready", 32'(hreadyout_o), 32'd0);
    rstn = 1'b0;
    #1;
    check("rw_req", 32'(req_o), 32'd0);
    check("rw_hready", 32'(hreadyout_o), 32'd1);
    check("rw_hresp", 32'(hresp_o), 32'd0);
    check("rw_hrdata", hrdata_o, 32'h0);
    check("rw_addr", addr_o, 32'h0);
    cyc();
    rstn = 1'b1; rvalid_i = 1'b1; rdata_i = 32'hCAFEF00D;
    cyc();
    rvalid_i = 1'b0;
    check("rw_late_hrdata", hrdata_o, 32'h0);
    check("rw_late_hready", 32'(hreadyout_o), 32'd1);
    check("rw_late_req", 32'(req_o), 32'd0);
    $display("txn: reset during WAIT, late rvalid ignored");
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
